div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions in the Falco execute stage.
- Complements the single-cycle ALU: it takes the same decoded operands and returns the result to the execute/writeback mux over a valid/ready handshake.
- The pipeline stalls on req_ready/resp_valid while a divide is in flight.

Parameters:
- XLEN, 32, operand and result width (only 32 is supported).
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill the in-flight operation (branch mispredict or trap).
- req_valid  in  1  operands and op are valid.
- req_ready  out  1  unit can accept a request.
- a  in  XLEN  dividend (rs1).
- b  in  XLEN  divisor (rs2).
- div_op_sel  in  2  bit0 = unsigned, bit1 = return remainder; DIV=00, DIVU=01, REM=10, REMU=11 (equals funct3[1:0]).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- div_result  out  XLEN  quotient or remainder.

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; div_result=0; all internal registers cleared.
- States are IDLE, CALC and DONE.
- IDLE:
  - req_ready=1.
  - Accept when req_valid && !flush.
  - On accept, latch op, neg_q = signed && (a[31]^b[31]), and neg_r = signed && a[31].
- Special-case fast paths, decided at accept time:
  - b==0: q=all ones (0xFFFFFFFF) and r=a for both signed and unsigned ops. Go to DONE with neg flags cleared.
  - Signed overflow (a==0x80000000 && b==0xFFFFFFFF): q=0x80000000, r=0. Go to DONE with neg flags cleared.
  - Otherwise: dividend register = |a| (or a if unsigned), divisor register = |b|, rem=0, cnt=XLEN-1. Go to CALC.
- CALC, one restoring step per cycle:
  - rem' = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd shifts left by 1.
  - If rem' >= divisor: rem = rem' - divisor and dvd[0]=1. Otherwise rem=rem' and dvd[0]=0.
  - Compare and subtract use XLEN+1 bits.
  - After the step where cnt==0, go to DONE; otherwise cnt decrements.
- DONE:
  - resp_valid = !flush; req_ready=0.
  - div_result = op.rem ? (neg_r ? -rem : rem) : (neg_q ? -q : q). This is combinational from registers.
  - Stays in DONE and holds div_result stable until resp_ready; on resp_valid && resp_ready, go to IDLE.
- Latency:
  - Normal path: accept in cycle 0, CALC in cycles 1..32, resp_valid first in cycle 33.
  - Special path: resp_valid in cycle 1.
  - Throughput is one op per 34 cycles minimum; there is no same-cycle re-accept in DONE.
- flush:
  - In any state, the next state is IDLE and no response is produced.
  - flush in IDLE blocks acceptance of a request in the same cycle.
  - flush in DONE suppresses resp_valid in that cycle, even if resp_ready=1.
- rst overrides flush and everything else; rst mid-CALC returns to IDLE the next cycle with no response.
- Signs:
  - The remainder takes the sign of the dividend; the quotient truncates toward zero (RISC-V semantics).
  - Unsigned ops never negate.
- Request inputs are sampled only at accept; a, b and div_op_sel may change freely afterwards.

Decomposition:
- Falco_pkg gains:
  - div_op_t, a 2-bit enum: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - div_state_t, an enum: DIV_IDLE, DIV_CALC, DIV_DONE.
  - The constant DIV_LATENCY=33.
- Datapath and FSM stay in one module; no sub-module is needed.
- The restoring step may be written as a function within the module.

Test Plan:
- DIV 7/2 -> resp_valid at cycle 33, result 0x00000003. REM 7/2 -> 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU -> 0x00000001.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005. Both valid at cycle 1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000. Both valid at cycle 1.
- flush at cycle 10 of a DIVU -> IDLE next cycle, no resp_valid ever. A following DIVU 100/7 -> 0x0000000E after 33 cycles.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and div_result stable, req_ready=0. Raise resp_ready -> IDLE next cycle with req_ready=1.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Operation encoding matches funct3[1:0] of DIV/DIVU/REM/REMU.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_CALC,
      DIV_DONE
   } div_state_t;

   // Cycles from accept to the first cycle resp_valid is high on the normal path
   localparam int unsigned DIV_LATENCY = 33;

   function automatic logic op_is_unsigned(input div_op_t op);
      return (op == DIV_OP_DIVU) || (op == DIV_OP_REMU);
   endfunction

   function automatic logic op_is_rem(input div_op_t op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready request and response.
// Magnitudes are divided; signs are reapplied combinationally on the way out.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      div_op_sel,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] div_result
);

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t       state_q;
   div_op_t          op_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [XLEN-1:0]  dvd_q;
   logic [XLEN-1:0]  dvs_q;
   logic [XLEN-1:0]  rem_q;
   logic [CNT_W-1:0] cnt_q;

   div_op_t          req_op;
   logic             req_signed;
   logic [XLEN-1:0]  abs_a;
   logic [XLEN-1:0]  abs_b;
   logic [2*XLEN-1:0] step;

   // The partial remainder is widened by one bit so unsigned divisors above 2**(XLEN-1)
   // never lose the top bit of the shifted remainder.
   function automatic logic [2*XLEN-1:0] restore_step(input logic [XLEN-1:0] rem,
                                                      input logic [XLEN-1:0] dvd,
                                                      input logic [XLEN-1:0] dvs);
      logic [XLEN:0] shifted;
      logic [XLEN:0] diff;
      shifted = {rem, dvd[XLEN-1]};
      diff    = shifted - {1'b0, dvs};
      if (shifted >= {1'b0, dvs}) begin
         return {diff[XLEN-1:0], dvd[XLEN-2:0], 1'b1};
      end
      return {shifted[XLEN-1:0], dvd[XLEN-2:0], 1'b0};
   endfunction

   always_comb begin
      req_op     = div_op_t'(div_op_sel);
      req_signed = !op_is_unsigned(req_op);
      abs_a      = (req_signed && a[XLEN-1]) ? -a : a;
      abs_b      = (req_signed && b[XLEN-1]) ? -b : b;
      step       = restore_step(rem_q, dvd_q, dvs_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         op_q      <= DIV_OP_DIV;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
      end else if (flush) begin
         state_q <= DIV_IDLE;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (req_valid) begin
                  op_q <= req_op;
                  if (b == '0) begin
                     dvd_q     <= '1;
                     rem_q     <= a;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     state_q   <= DIV_DONE;
                  end else if (req_signed && (a == MinInt) && (b == '1)) begin
                     dvd_q     <= MinInt;
                     rem_q     <= '0;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     state_q   <= DIV_DONE;
                  end else begin
                     dvd_q     <= abs_a;
                     dvs_q     <= abs_b;
                     rem_q     <= '0;
                     cnt_q     <= CNT_W'(XLEN - 1);
                     neg_quo_q <= req_signed && (a[XLEN-1] ^ b[XLEN-1]);
                     neg_rem_q <= req_signed && a[XLEN-1];
                     state_q   <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem_q <= step[2*XLEN-1:XLEN];
               dvd_q <= step[XLEN-1:0];
               if (cnt_q == '0) begin
                  state_q <= DIV_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DIV_DONE: begin
               if (resp_ready) begin
                  state_q <= DIV_IDLE;
               end
            end
            default: state_q <= DIV_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready  = (state_q == DIV_IDLE);
      resp_valid = (state_q == DIV_DONE) && !flush;
      if (op_is_rem(op_q)) begin
         div_result = neg_rem_q ? -rem_q : rem_q;
      end else begin
         div_result = neg_quo_q ? -dvd_q : dvd_q;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic results, fast-path latency, flush, reset and
// response backpressure, all against hand-computed expectations.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  div_op_sel;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] div_result;

   int checks = 0;
   int errors = 0;

   div_unit #(
      .XLEN (32),
      .CNT_W(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a         (a),
      .b         (b),
      .div_op_sel(div_op_sel),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .div_result(div_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns with the cycle after accept current (cycle 1).
   task automatic issue(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input string tag);
      div_op_sel = op;
      a          = va;
      b          = vb;
      req_valid  = 1'b1;
      check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      req_valid  = 1'b0;
      a          = $urandom;
      b          = $urandom;
      div_op_sel = 2'($urandom_range(3, 0));
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input int exp_lat, input logic [31:0] exp_res, input string tag);
      int lat;
      issue(op, va, vb, tag);
      wait_resp(lat);
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".result"}, div_result, exp_res);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, ".idle_after"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      rst        = 1'b1;
      flush      = 1'b0;
      req_valid  = 1'b0;
      a          = '0;
      b          = '0;
      div_op_sel = 2'b00;
      resp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset.req_ready", {31'd0, req_ready}, 32'd1);
      check("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("reset.div_result", div_result, 32'h0000_0000);

      run_op(2'b00, 32'd7, 32'd2, DIV_LATENCY, 32'h0000_0003, "div_7_2");
      run_op(2'b10, 32'd7, 32'd2, DIV_LATENCY, 32'h0000_0001, "rem_7_2");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, DIV_LATENCY, 32'hFFFF_FFFD, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, DIV_LATENCY, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(2'b01, 32'hFFFF_FFF9, 32'd2, DIV_LATENCY, 32'h7FFF_FFFC, "divu_big_2");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, DIV_LATENCY, 32'h0000_0001, "remu_big_2");
      run_op(2'b00, 32'd100, 32'hFFFF_FFF9, DIV_LATENCY, 32'hFFFF_FFF2, "div_100_m7");
      run_op(2'b10, 32'd100, 32'hFFFF_FFF9, DIV_LATENCY, 32'h0000_0002, "rem_100_m7");
      run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, DIV_LATENCY, 32'h7FFF_FFFE, "remu_wide");
      run_op(2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div_by_zero");
      run_op(2'b11, 32'd5, 32'd0, 1, 32'h0000_0005, "remu_by_zero");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "rem_ovf");

      // Flush in IDLE must block the concurrent request
      req_valid = 1'b1;
      flush     = 1'b1;
      a         = 32'd9;
      b         = 32'd3;
      tick();
      req_valid = 1'b0;
      flush     = 1'b0;
      check("flush_idle.req_ready", {31'd0, req_ready}, 32'd1);

      // Flush at cycle 10 of a DIVU
      issue(2'b01, 32'd1000, 32'd3, "flush_calc");
      for (int i = 1; i < 10; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_calc.req_ready", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      check("flush_calc.no_resp", 32'(seen), 32'd0);
      run_op(2'b01, 32'd100, 32'd7, DIV_LATENCY, 32'h0000_000E, "divu_100_7");

      // Reset mid-CALC
      issue(2'b00, 32'd50, 32'd5, "rst_calc");
      for (int i = 1; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_calc.req_ready", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      check("rst_calc.no_resp", 32'(seen), 32'd0);

      // Flush in DONE suppresses resp_valid even with resp_ready high
      issue(2'b00, 32'd5, 32'd0, "flush_done");
      check("flush_done.valid_before", {31'd0, resp_valid}, 32'd1);
      flush      = 1'b1;
      resp_ready = 1'b1;
      #1;
      check("flush_done.valid_masked", {31'd0, resp_valid}, 32'd0);
      tick();
      flush      = 1'b0;
      resp_ready = 1'b0;
      check("flush_done.req_ready", {31'd0, req_ready}, 32'd1);
      check("flush_done.valid_after", {31'd0, resp_valid}, 32'd0);

      // Backpressure: hold the response for 5 cycles
      issue(2'b00, 32'd7, 32'd2, "bp");
      wait_resp(lat);
      check("bp.latency", 32'(lat), 32'(DIV_LATENCY));
      for (int i = 0; i < 5; i++) begin
         check("bp.hold_valid", {31'd0, resp_valid}, 32'd1);
         check("bp.hold_result", div_result, 32'h0000_0003);
         check("bp.hold_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("bp.release_req_ready", {31'd0, req_ready}, 32'd1);
      check("bp.release_valid", {31'd0, resp_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
